// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, the NOP word and the fetch-stage state enum.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD      = 4'b0000,
    OP_SUBTRACT = 4'b0001,
    OP_AND      = 4'b0010,
    OP_OR       = 4'b0011,
    OP_XOR      = 4'b0100,
    OP_NOT      = 4'b0101,
    OP_LOAD     = 4'b0110,
    OP_STORE    = 4'b0111,
    OP_NOP      = 4'b1111
  } opcode_e;

  localparam logic [15:0] NOP_INSTRUCTION = 16'h000F;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2,
    FETCH_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, combinational ROM port and the valid/ready link to decode.
interface instruction_fetch_if #(
  parameter int BITS_FOR_INSTRUCTIONS = 5,
  parameter int INSTRUCTION_WIDTH     = 16
);
  logic                             enable;
  logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address;
  logic [INSTRUCTION_WIDTH-1:0]     instruction;
  logic                             redirect_valid;
  logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_address;
  logic                             fetch_valid;
  logic                             fetch_ready;
  logic [INSTRUCTION_WIDTH-1:0]     fetched_instruction;
  logic [3:0]                       fetched_opcode;
  logic [BITS_FOR_INSTRUCTIONS-1:0] fetched_pc;
  logic                             halted;

  modport master (
    input  enable, instruction, redirect_valid, redirect_address, fetch_ready,
    output instruction_address, fetch_valid, fetched_instruction, fetched_opcode,
           fetched_pc, halted
  );

  modport slave (
    output enable, instruction, redirect_valid, redirect_address, fetch_ready,
    input  instruction_address, fetch_valid, fetched_instruction, fetched_opcode,
           fetched_pc, halted
  );
endinterface

// File: rtl/instruction_fetch_output_reg.sv
// Valid/ready pipeline register holding the fetched word and its address; flush beats load beats accept.
module fetch_output_reg
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              accept_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Next-state selection for the holding register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (accept_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Register update; reset presents a NOP from address zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= DATA_W'(NOP_INSTRUCTION);
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, IDLE/RUN/DRAIN/HALT control and redirect handling in front of program_memory.
// Define FETCH_WRAP_EN to loop back to address 0 after the last instruction instead of draining.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int BITS_FOR_INSTRUCTIONS  = 5,
  parameter int INSTRUCTION_WIDTH      = 16,
  parameter int NUMBER_OF_INSTRUCTIONS = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] LAST_PC =
    BITS_FOR_INSTRUCTIONS'(NUMBER_OF_INSTRUCTIONS - 1);
  localparam logic [BITS_FOR_INSTRUCTIONS-1:0] PC_ONE = BITS_FOR_INSTRUCTIONS'(1);

  fetch_state_e                     state_q, state_d;
  logic [BITS_FOR_INSTRUCTIONS-1:0] pc_q, pc_d;
  logic                             halted_q;
  logic                             fetch_valid_s;
  logic                             accept_s;
  logic                             load_s;
  logic                             out_of_range_s;
  logic [INSTRUCTION_WIDTH-1:0]     fetched_instruction_s;

  assign accept_s       = fetch_valid_s && bus.fetch_ready;
  assign out_of_range_s = (32'(bus.redirect_address) >= 32'(NUMBER_OF_INSTRUCTIONS));
  assign load_s = ((state_q == FETCH_RUN) || ((state_q == FETCH_IDLE) && bus.enable))
                  && (!fetch_valid_s || bus.fetch_ready) && !bus.redirect_valid;

  // Next PC and control state; a redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect_valid) begin
      if (out_of_range_s) begin
        state_d = FETCH_HALT;
      end else begin
        pc_d    = bus.redirect_address;
        state_d = bus.enable ? FETCH_RUN : FETCH_IDLE;
      end
    end else if (load_s) begin
      if (pc_q == LAST_PC) begin
`ifdef FETCH_WRAP_EN
        pc_d    = '0;
        state_d = FETCH_RUN;
`else
        state_d = FETCH_DRAIN;
`endif
      end else begin
        pc_d    = pc_q + PC_ONE;
        state_d = FETCH_RUN;
      end
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (!bus.enable) state_d = FETCH_IDLE;
          else             state_d = FETCH_RUN;
        end
        FETCH_DRAIN: begin
          if (!fetch_valid_s || accept_s) state_d = FETCH_HALT;
          else                            state_d = FETCH_DRAIN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // State, PC and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == FETCH_HALT);
    end
  end

  fetch_output_reg #(
    .ADDR_W (BITS_FOR_INSTRUCTIONS),
    .DATA_W (INSTRUCTION_WIDTH)
  ) u_output_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .flush_i  (bus.redirect_valid),
    .accept_i (accept_s),
    .data_i   (bus.instruction),
    .pc_i     (pc_q),
    .valid_o  (fetch_valid_s),
    .data_o   (fetched_instruction_s),
    .pc_o     (bus.fetched_pc)
  );

  assign bus.instruction_address = pc_q;
  assign bus.fetch_valid         = fetch_valid_s;
  assign bus.fetched_instruction = fetched_instruction_s;
  assign bus.fetched_opcode      = fetched_instruction_s[3:0];
  assign bus.halted              = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a 32-word DUT against a behavioural model,
// plus a 20-word DUT for the out-of-range redirect case.
module tb_instruction_fetch;
  import cpu_pkg::*;

  localparam int N_A = 32;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16)) bus_a ();
  instruction_fetch_if #(.BITS_FOR_INSTRUCTIONS(5), .INSTRUCTION_WIDTH(16)) bus_b ();

  instruction_fetch #(.NUMBER_OF_INSTRUCTIONS(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  instruction_fetch #(.NUMBER_OF_INSTRUCTIONS(20)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [15:0] rom [0:31];
  assign bus_a.instruction = rom[bus_a.instruction_address];
  assign bus_b.instruction = rom[bus_b.instruction_address];

  int checks = 0;
  int failures = 0;

  // Behavioural model of dut_a
  logic [4:0]  m_pc;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [4:0]  m_fpc;
  int          m_ph;

  logic [31:0] dut_vec;
  assign dut_vec = {bus_a.fetch_valid, bus_a.fetched_pc, bus_a.fetched_instruction,
                    bus_a.fetched_opcode, bus_a.instruction_address, bus_a.halted};

  function automatic logic [31:0] exp_vec();
    return {m_valid, m_fpc, m_instr, m_instr[3:0], m_pc, (m_ph == PH_HALT)};
  endfunction

  task automatic model_reset();
    m_pc = 5'd0; m_valid = 1'b0; m_instr = 16'h000F; m_fpc = 5'd0; m_ph = PH_IDLE;
  endtask

  task automatic apply_reset();
    bus_a.enable = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_address = 5'd0;
    bus_a.fetch_ready = 1'b0;
    bus_b.enable = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.redirect_address = 5'd0;
    bus_b.fetch_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of dut_a with the model advanced by the fetch rules.
  task automatic step(input logic en, input logic rv, input logic [4:0] ra, input logic rdy);
    logic [4:0] n_pc; logic n_valid; logic [15:0] n_instr; logic [4:0] n_fpc; int n_ph;
    logic fire, ld;
    bus_a.enable = en; bus_a.redirect_valid = rv; bus_a.redirect_address = ra;
    bus_a.fetch_ready = rdy;
    n_pc = m_pc; n_valid = m_valid; n_instr = m_instr; n_fpc = m_fpc; n_ph = m_ph;
    fire = m_valid && rdy;
    ld = ((m_ph == PH_RUN) || (m_ph == PH_IDLE && en)) && (!m_valid || rdy) && !rv;
    if (rv) begin
      n_valid = 1'b0;
      if (int'(ra) >= N_A) n_ph = PH_HALT;
      else begin n_pc = ra; n_ph = en ? PH_RUN : PH_IDLE; end
    end else if (ld) begin
      n_instr = rom[m_pc]; n_fpc = m_pc; n_valid = 1'b1;
      if (int'(m_pc) == N_A - 1) begin
`ifdef FETCH_WRAP_EN
        n_pc = 5'd0; n_ph = PH_RUN;
`else
        n_ph = PH_DRAIN;
`endif
      end else begin
        n_pc = 5'(int'(m_pc) + 1); n_ph = PH_RUN;
      end
    end else begin
      if (fire) n_valid = 1'b0;
      if (m_ph == PH_RUN && !en) n_ph = PH_IDLE;
      if (m_ph == PH_DRAIN && (!m_valid || fire)) n_ph = PH_HALT;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_valid = n_valid; m_instr = n_instr; m_fpc = n_fpc; m_ph = n_ph;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec());
    end
    checks++;
    if (bus_a.fetched_instruction !== 16'h000F || bus_a.fetched_opcode !== 4'hF) begin
      failures++;
      $display("FAIL reset_nop got=%h/%h exp=000f/f", bus_a.fetched_instruction, bus_a.fetched_opcode);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL stream_vec[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
      checks++;
      if (bus_a.fetched_pc !== 5'(i) || bus_a.fetch_valid !== 1'b1
          || bus_a.fetched_instruction !== rom[i]) begin
        failures++;
        $display("FAIL stream_pc[%0d] got=%0d/%b/%h exp=%0d/1/%h", i, bus_a.fetched_pc,
                 bus_a.fetch_valid, bus_a.fetched_instruction, i, rom[i]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (5) step(1'b1, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b0);
      checks++;
      if (bus_a.fetched_pc !== 5'd4 || bus_a.instruction_address !== 5'd5
          || bus_a.fetch_valid !== 1'b1 || bus_a.fetched_instruction !== rom[4]) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=pc%0d addr%0d v%b %h exp=pc4 addr5 v1 %h", i,
                 bus_a.fetched_pc, bus_a.instruction_address, bus_a.fetch_valid,
                 bus_a.fetched_instruction, rom[4]);
      end
    end
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (bus_a.fetched_pc !== 5'd5 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL stall_resume got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_redirect();
    logic [15:0] store_word;
    store_word = {2'b01, 10'd0, OP_STORE};
    apply_reset();
    repeat (4) step(1'b1, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b1, 5'd10, 1'b1);
    checks++;
    if (bus_a.fetch_valid !== 1'b0 || bus_a.instruction_address !== 5'd10) begin
      failures++;
      $display("FAIL redirect_bubble got=v%b addr%0d exp=v0 addr10", bus_a.fetch_valid,
               bus_a.instruction_address);
    end
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (bus_a.fetched_pc !== 5'd10 || bus_a.fetched_instruction !== store_word
        || bus_a.fetched_opcode !== OP_STORE || bus_a.fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL redirect_target got=pc%0d %h op%h exp=pc10 %h op7", bus_a.fetched_pc,
               bus_a.fetched_instruction, bus_a.fetched_opcode, store_word);
    end
  endtask

  task automatic test_end_of_program();
    apply_reset();
    step(1'b1, 1'b1, 5'd28, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b1);
      checks++;
      if (bus_a.fetched_pc !== 5'(28 + i) || dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL eop_run[%0d] got=pc%0d exp=pc%0d", i, bus_a.fetched_pc, 28 + i);
      end
    end
    repeat (2) step(1'b1, 1'b0, 5'd0, 1'b0);
`ifdef FETCH_WRAP_EN
    checks++;
    if (bus_a.fetched_pc !== 5'd31 || bus_a.instruction_address !== 5'd0) begin
      failures++;
      $display("FAIL eop_wrap_hold got=pc%0d addr%0d exp=pc31 addr0", bus_a.fetched_pc,
               bus_a.instruction_address);
    end
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (bus_a.fetched_pc !== 5'd0 || bus_a.fetch_valid !== 1'b1 || bus_a.halted !== 1'b0) begin
      failures++;
      $display("FAIL eop_wrap got=pc%0d v%b h%b exp=pc0 v1 h0", bus_a.fetched_pc,
               bus_a.fetch_valid, bus_a.halted);
    end
`else
    checks++;
    if (bus_a.fetched_pc !== 5'd31 || bus_a.fetch_valid !== 1'b1 || bus_a.halted !== 1'b0) begin
      failures++;
      $display("FAIL eop_drain got=pc%0d v%b h%b exp=pc31 v1 h0", bus_a.fetched_pc,
               bus_a.fetch_valid, bus_a.halted);
    end
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (bus_a.halted !== 1'b1 || bus_a.fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL eop_halt got=h%b v%b exp=h1 v0", bus_a.halted, bus_a.fetch_valid);
    end
`endif
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL eop_vec got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    bus_b.enable = 1'b1; bus_b.fetch_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_b.fetched_pc !== 5'd2 || bus_b.fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL oor_pre got=pc%0d v%b exp=pc2 v1", bus_b.fetched_pc, bus_b.fetch_valid);
    end
    bus_b.redirect_valid = 1'b1; bus_b.redirect_address = 5'd31;
    @(posedge clk);
    #1;
    bus_b.redirect_valid = 1'b0;
    checks++;
    if (bus_b.halted !== 1'b1 || bus_b.fetch_valid !== 1'b0 || bus_b.instruction_address !== 5'd3) begin
      failures++;
      $display("FAIL oor_halt got=h%b v%b addr%0d exp=h1 v0 addr3", bus_b.halted,
               bus_b.fetch_valid, bus_b.instruction_address);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_b.halted !== 1'b1 || bus_b.fetch_valid !== 1'b0 || bus_b.instruction_address !== 5'd3) begin
      failures++;
      $display("FAIL oor_stay got=h%b v%b addr%0d exp=h1 v0 addr3", bus_b.halted,
               bus_b.fetch_valid, bus_b.instruction_address);
    end
    bus_b.enable = 1'b0; bus_b.fetch_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (3) step(1'b1, 1'b0, 5'd0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.fetch_valid !== 1'b0 || bus_a.fetched_instruction !== 16'h000F
        || bus_a.instruction_address !== 5'd0 || bus_a.halted !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=v%b %h addr%0d exp=v0 000f addr0", bus_a.fetch_valid,
               bus_a.fetched_instruction, bus_a.instruction_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 5'd0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      failures++; $display("FAIL async_restart got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic en, rv, rdy; logic [4:0] ra;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      ra  = 5'($urandom_range(0, 31));
      step(en, rv, ra, rdy);
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    rom[10] = {2'b01, 10'd0, OP_STORE};
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_end_of_program();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of `program_memory`.
- Holds the program counter and drives it as the ROM's combinational read address.
- Captures the returned 16-bit instruction into an output register.
- Presents it to decode over a valid/ready handshake.
- Supports stall, PC redirect, and end-of-program halt.

## Interface
- `BITS_FOR_INSTRUCTIONS`, 5, PC/address width
- `INSTRUCTION_WIDTH`, 16, instruction word width
- `NUMBER_OF_INSTRUCTIONS`, 32, program length; last valid address is N-1
- `clk  in  1`  single clock, rising edge
- `rst_n  in  1`  reset, asynchronous, active-low
- `enable  in  1`  level; permits new fetches
- `instruction_address  out  BITS_FOR_INSTRUCTIONS`  to ROM; equals PC register
- `instruction  in  INSTRUCTION_WIDTH`  combinational ROM data for `instruction_address`
- `redirect_valid  in  1`  one-cycle PC load request
- `redirect_address  in  BITS_FOR_INSTRUCTIONS`  redirect target
- `fetch_valid  out  1`  output register holds an instruction
- `fetch_ready  in  1`  decode accepts; transfer when valid&&ready
- `fetched_instruction  out  INSTRUCTION_WIDTH`  registered instruction
- `fetched_opcode  out  4`  `fetched_instruction[3:0]`
- `fetched_pc  out  BITS_FOR_INSTRUCTIONS`  address the instruction came from
- `halted  out  1`  state HALT

## Operation
- FSM states: IDLE, RUN, DRAIN, HALT.
- Load condition: `L = (state==RUN || (state==IDLE && enable)) && (!fetch_valid || fetch_ready) && !redirect_valid`.
- On L:
  - `fetched_instruction<=instruction`, `fetched_pc<=pc`, `fetch_valid<=1`.
  - `pc<=pc+1`, unsigned, width `BITS_FOR_INSTRUCTIONS`.
- Not L, handshake fires: `fetch_valid<=0`.
- Not L, `fetch_valid && !fetch_ready`: all output fields held stable.
- IDLE→RUN on L.
- RUN→IDLE when `enable==0`, no load. A held instruction stays valid until accepted.
- Load from `pc==NUMBER_OF_INSTRUCTIONS-1`: end-of-program, see Configuration.
- DRAIN→HALT when the last instruction is accepted, or when `fetch_valid==0`.
- HALT: no fetches; `fetch_valid=0`.
- Redirect, any state, highest priority:
  - `pc<=redirect_address`, `fetch_valid<=0` (flush, no load that cycle).
  - Next state RUN if `enable`, else IDLE.
  - A handshake coinciding with the redirect still counts as accepted.
- `redirect_address >= NUMBER_OF_INSTRUCTIONS`: PC unchanged, flush, next state HALT.
- Opcode field is decoded only into `fetched_opcode`; no instruction-dependent control flow.

## Timing
- Reset values:
  - `pc=0`, state IDLE, `fetch_valid=0`, `halted=0`.
  - `fetched_instruction=16'h000F` (NOP), `fetched_opcode=4'hF`, `fetched_pc=0`.
- `instruction_address` is combinational from `pc`, so the ROM word is sampled the same cycle.
- Latency: `enable` high at edge k → `fetch_valid=1` after edge k, holding word at `pc`.
- Throughput: one instruction per cycle while `fetch_ready=1`.
- Stall: `fetch_ready=0` freezes `pc` and all outputs from the next edge until ready.
- Redirect at edge k:
  - `fetch_valid=0` after k.
  - First target word valid after k+1 (one bubble).
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous). Deassertion is synchronised by the user.

## Configuration
- `FETCH_WRAP_EN` defined:
  - Load from address N-1 sets `pc<=0` and stays in RUN.
  - Execution loops forever; DRAIN/HALT reached only via out-of-range redirect.
- Not defined:
  - Load from N-1 leaves `pc` at N-1 and moves to DRAIN.
  - HALT follows after the last instruction is accepted.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (ADD 0000, SUBTRACT 0001, AND 0010, OR 0011, XOR 0100, NOT 0101, LOAD 0110, STORE 0111, NOP 1111)
  - `NOP_INSTRUCTION = 16'h000F`
  - fetch-state enum
- One sub-module, `fetch_output_reg`: the valid/ready pipeline register (data+pc+valid, load/flush/hold).
- PC and FSM stay in `instruction_fetch`.

## Test plan
- Reset, `enable=1`, `fetch_ready=1` → `fetched_pc` 0,1,2,… on consecutive cycles; `fetched_instruction` matches ROM words; `fetch_valid` high from the first edge after enable.
- `fetch_ready=0` for 3 cycles while holding pc=4 → `fetched_pc=4`, instruction, and `instruction_address=5` all stable; resume yields 5 next.
- `redirect_valid=1`, `redirect_address=10` while valid holds pc=3 → one-cycle bubble (`fetch_valid=0`), then `fetched_pc=10`, instruction `{2'b01,10'd0,STORE}`.
- Without `FETCH_WRAP_EN`: run to pc=31 with ready low at the end → DRAIN holds word 31; ready high → `halted=1`, `fetch_valid=0`. With the macro: pc 31 followed by 0.
- `redirect_address=31` with `NUMBER_OF_INSTRUCTIONS=20` → flush, `halted=1`, PC unchanged.
- `rst_n` pulsed low mid-stall → outputs immediately `fetch_valid=0`, `fetched_instruction=16'h000F`, `instruction_address=0`.
